data_memory: RTL and testbench
==============================

// Module: data_memory
// PURPOSE
//  Single-port, address-less sample memory for the DSP datapath. Operates as a
//  circular store (delay line) of DEPTH words. Each enabled write stores write_data
//  at an internal write pointer and presents the word it overwrites, so data is
//  the sample written exactly DEPTH enabled writes earlier. Sits between the
//  sample source and the filter/accumulator stages.
// PARAMETERS
//  WIDTH   32   word width in bits (write_data, data, storage entries)
//  DEPTH   16   number of stored words = delay in enabled writes; legal range 1..1024
//  PTR_W   $clog2(DEPTH) (min 1)   width of the internal write pointer (localparam)
// PORTS
//  clk           in   1      rising-edge clock; sole clock domain
//  rst_n         in   1      asynchronous active-low reset
//  write_data    in   WIDTH  sample to store
//  write_enable  in   1      1 = store write_data this cycle and advance pointer
//  data          out  WIDTH  registered output: word evicted by the latest enabled write
// BEHAVIOUR
//  - Reset (rst_n=0, async assert, sync release on next clk edge):
//    data=0, write pointer=0, all DEPTH entries=0. Held while rst_n=0.
//  - Rising clk edge with write_enable=1:
//    data <= mem[ptr]; mem[ptr] <= write_data;
//    ptr <= (ptr==DEPTH-1) ? 0 : ptr+1. Read-before-write on the same entry.
//  - Rising clk edge with write_enable=0: mem, ptr, data all hold.
//  - Latency: data updates at the same edge as the enabled write (1-cycle,
//    registered output); value equals the word written DEPTH enabled writes
//    earlier, or 0 if fewer than DEPTH writes have occurred since reset.
//  - Wrap-around: pointer wraps DEPTH-1 -> 0 for any DEPTH, including non-powers of 2.
//  - DEPTH=1: block degenerates to a 1-word register; data = previous enabled word.
//  - X on write_enable is not permitted; write_data is stored bit-exact, no arithmetic.
//  - Reset mid-stream discards all contents; the first DEPTH post-reset writes
//    evict 0.
//  - No read port, no full/empty flags: the store is always full and writes
//    never stall.
// TESTING
//  1) Reset: rst_n=0 mid-cycle with clk idle -> data=0 immediately (async),
//     stays 0 after release with write_enable=0.
//  2) Fill: DEPTH=16; write 0x12345678, then 0x0000FF00, 0x0000FF00, ... (16
//     enabled writes) -> data=0 after each; 17th write -> data=0x12345678.
//  3) Steady stream: write values 1..40 consecutively -> after write k (k>16),
//     data=k-16.
//  4) Enable gating: write 0xA, deassert write_enable for 5 cycles, then resume
//     -> data/pointer frozen while idle; 0xA appears exactly 16 enabled writes
//     later.
//  5) Wrap at non-power-of-2: DEPTH=5; write 0x1..0xC -> write 6 returns 0x1,
//     write 11 returns 0x6.
//  6) Reset mid-operation: after 20 writes pulse rst_n low -> data=0; next 16
//     writes return 0, 17th returns first post-reset word.

Source files
------------

// File: rtl/data_memory.sv
// Circular sample store (delay line): each enabled write stores a word and
// returns the word written DEPTH enabled writes earlier (zero after reset).
module data_memory #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] write_data,
    input  logic             write_enable,
    output logic [WIDTH-1:0] data
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;
    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] rd_word;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0] wsel;

    // One-hot entry select; storage is register-based so reset can clear every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wsel
            assign wsel[gi] = write_enable && (ptr_q == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == PTR_W'(i)) begin
                rd_word = mem_q[i];
            end
        end
    end

    always_comb begin
        ptr_d  = ptr_q;
        data_d = data_q;
        if (write_enable) begin
            data_d = rd_word;
            ptr_d  = (ptr_q == LAST_PTR) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q  <= '0;
            data_q <= '0;
        end else begin
            ptr_q  <= ptr_d;
            data_q <= data_d;
        end
    end

    // The evicted word is sampled from the old contents at the same edge it is overwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wsel[i]) begin
                    mem_q[i] <= write_data;
                end
            end
        end
    end

    assign data = data_q;

endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory at DEPTH=16, DEPTH=5 and DEPTH=1.
module tb_data_memory;

    logic        clk;
    logic        rst16_n, we16;
    logic [31:0] wd16, d16;
    logic        rst5_n, we5;
    logic [31:0] wd5, d5;
    logic        rst1_n, we1;
    logic [31:0] wd1, d1;

    int passed;
    int total;

    data_memory #(.WIDTH(32), .DEPTH(16)) dut16 (
        .clk(clk), .rst_n(rst16_n), .write_data(wd16), .write_enable(we16), .data(d16)
    );
    data_memory #(.WIDTH(32), .DEPTH(5)) dut5 (
        .clk(clk), .rst_n(rst5_n), .write_data(wd5), .write_enable(we5), .data(d5)
    );
    data_memory #(.WIDTH(32), .DEPTH(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .write_data(wd1), .write_enable(we1), .data(d1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
    task automatic write16(input logic [31:0] v);
        @(negedge clk);
        we16 = 1'b1;
        wd16 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic idle16();
        @(negedge clk);
        we16 = 1'b0;
        wd16 = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
    endtask

    task automatic write5(input logic [31:0] v);
        @(negedge clk);
        we5 = 1'b1;
        wd5 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic write1(input logic [31:0] v);
        @(negedge clk);
        we1 = 1'b1;
        wd1 = v;
        @(posedge clk);
        #1;
    endtask

    task automatic reset16();
        @(negedge clk);
        we16    = 1'b0;
        rst16_n = 1'b0;
        @(negedge clk);
        rst16_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #2;
        rst16_n = 1'b0;
        #1;
        total++;
        if (d16 !== 32'h0) $display("FAIL reset_async: got %h expected %h", d16, 32'h0);
        else passed++;
        @(negedge clk);
        rst16_n = 1'b1;
        we16    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (d16 !== 32'h0) $display("FAIL reset_hold%0d: got %h expected %h", i, d16, 32'h0);
            else passed++;
        end
        $display("reset: data=%h", d16);
    endtask

    task automatic test_fill();
        reset16();
        for (int k = 1; k <= 17; k++) begin
            logic [31:0] v;
            logic [31:0] exp;
            v   = (k == 1) ? 32'h1234_5678 : 32'h0000_FF00;
            exp = (k == 17) ? 32'h1234_5678 : 32'h0;
            write16(v);
            total++;
            if (d16 !== exp) $display("FAIL fill_w%0d: got %h expected %h", k, d16, exp);
            else passed++;
            $display("fill write %0d: wd=%h data=%h", k, v, d16);
        end
        idle16();
    endtask

    task automatic test_stream();
        reset16();
        for (int k = 1; k <= 40; k++) begin
            logic [31:0] exp;
            exp = (k > 16) ? 32'(k - 16) : 32'h0;
            write16(32'(k));
            total++;
            if (d16 !== exp) $display("FAIL stream_w%0d: got %h expected %h", k, d16, exp);
            else passed++;
            $display("stream write %0d: data=%h", k, d16);
        end
    endtask

    // Continues from the stream: the store holds 25..40, oldest first.
    task automatic test_enable_gating();
        write16(32'hA);
        total++;
        if (d16 !== 32'd25) $display("FAIL gate_first: got %h expected %h", d16, 32'd25);
        else passed++;
        for (int i = 0; i < 5; i++) begin
            idle16();
            total++;
            if (d16 !== 32'd25) $display("FAIL gate_idle%0d: got %h expected %h", i, d16, 32'd25);
            else passed++;
            $display("gate idle %0d: data=%h", i, d16);
        end
        for (int k = 1; k <= 16; k++) begin
            logic [31:0] exp;
            exp = (k == 16) ? 32'hA : 32'(25 + k);
            write16(32'h100 + 32'(k));
            total++;
            if (d16 !== exp) $display("FAIL gate_resume%0d: got %h expected %h", k, d16, exp);
            else passed++;
            $display("gate resume %0d: data=%h", k, d16);
        end
        idle16();
    endtask

    task automatic test_wrap5();
        @(negedge clk);
        rst5_n = 1'b0;
        @(negedge clk);
        rst5_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            logic [31:0] exp;
            exp = (k > 5) ? 32'(k - 5) : 32'h0;
            write5(32'(k));
            total++;
            if (d5 !== exp) $display("FAIL wrap5_w%0d: got %h expected %h", k, d5, exp);
            else passed++;
            $display("wrap5 write %0d: data=%h", k, d5);
        end
        @(negedge clk);
        we5 = 1'b0;
    endtask

    task automatic test_depth1();
        @(negedge clk);
        rst1_n = 1'b0;
        @(negedge clk);
        rst1_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            logic [31:0] exp;
            exp = (k == 1) ? 32'h0 : 32'hC0DE_0000 + 32'(k - 1);
            write1(32'hC0DE_0000 + 32'(k));
            total++;
            if (d1 !== exp) $display("FAIL depth1_w%0d: got %h expected %h", k, d1, exp);
            else passed++;
            $display("depth1 write %0d: data=%h", k, d1);
        end
        @(negedge clk);
        we1 = 1'b0;
    endtask

    task automatic test_reset_mid();
        reset16();
        for (int k = 1; k <= 20; k++) begin
            write16(32'h200 + 32'(k));
            if (k > 16) begin
                total++;
                if (d16 !== 32'h200 + 32'(k - 16))
                    $display("FAIL mid_pre_w%0d: got %h expected %h", k, d16, 32'h200 + 32'(k - 16));
                else passed++;
            end
        end
        #2;
        rst16_n = 1'b0;
        #1;
        total++;
        if (d16 !== 32'h0) $display("FAIL mid_async: got %h expected %h", d16, 32'h0);
        else passed++;
        @(negedge clk);
        rst16_n = 1'b1;
        we16    = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            logic [31:0] exp;
            exp = (k == 17) ? 32'h301 : 32'h0;
            write16(32'h300 + 32'(k));
            total++;
            if (d16 !== exp) $display("FAIL mid_post_w%0d: got %h expected %h", k, d16, exp);
            else passed++;
            $display("post-reset write %0d: data=%h", k, d16);
        end
        idle16();
    endtask

    initial begin
        passed  = 0;
        total   = 0;
        rst16_n = 1'b0; we16 = 1'b0; wd16 = '0;
        rst5_n  = 1'b0; we5  = 1'b0; wd5  = '0;
        rst1_n  = 1'b0; we1  = 1'b0; wd1  = '0;
        repeat (2) @(negedge clk);
        rst16_n = 1'b1;
        rst5_n  = 1'b1;
        rst1_n  = 1'b1;

        test_reset();
        test_fill();
        test_stream();
        test_enable_gating();
        test_wrap5();
        test_depth1();
        test_reset_mid();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
